// File: rtl/uart_tx_cfg_if.sv
// FIFO read-side handshake between the TX FIFO and uart_tx_cfg.
// The FIFO is first-word-fall-through: data is the head word while data_ready is high,
// and one read_enable strobe removes that head word.
interface uart_tx_cfg_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  data_ready;
  logic                  read_enable;

  // FIFO side: presents the head word and reacts to the pop strobe
  modport master (
    output data,
    output data_ready,
    input  read_enable
  );

  // Transmitter side: consumes the head word and issues the pop strobe
  modport slave (
    input  data,
    input  data_ready,
    output read_enable
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter fed from a FWFT FIFO.
// Frames are START, 1..DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
// Frames are sent back-to-back with no idle gap while the FIFO has data.
// Optional feature: define UART_TX_PARITY_EN to add the parity_mode port and PARITY bit.
module uart_tx_cfg #(
  parameter int BIT_LENGTH_WIDTH = 16,
  parameter int DATA_WIDTH       = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  uart_tx_cfg_if.slave                fifo,
  input  logic [BIT_LENGTH_WIDTH-1:0] bit_length,
  input  logic [3:0]                  num_bits,
  input  logic                        two_stop,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]                  parity_mode,
`endif
  output logic                        txd,
  output logic                        busy
);

  localparam int NB_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_LENGTH_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [NB_W-1:0]             IDX_ONE = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  state_t                      state, state_next;
  logic [BIT_LENGTH_WIDTH-1:0] count, count_next;
  logic [NB_W-1:0]             index, index_next;
  logic [DATA_WIDTH-1:0]       word, word_next;
  logic [NB_W-1:0]             nbits, nbits_next;
  logic                        stop2, stop2_next;
  logic                        read_enable_q, read_enable_next;
  logic                        busy_next;
  logic                        txd_next;
  logic                        bit_done;
  logic                        frame_end;
  logic                        take;
  logic [NB_W-1:0]             nbits_in;
  logic                        data_bit;

`ifdef UART_TX_PARITY_EN
  logic [1:0]                  par_mode, par_mode_next;
  logic                        parity_on;
  logic                        parity_bit;

  assign parity_on = (par_mode == 2'b01) || (par_mode == 2'b10);
`endif

  // A num_bits of zero or beyond the data port width selects the full width
  assign nbits_in = ((num_bits == 4'd0) || (int'(num_bits) > DATA_WIDTH))
                    ? NB_W'(DATA_WIDTH) : NB_W'(num_bits);

  assign fifo.read_enable = read_enable_q;

  // Next-state logic: bit timing, bit sequencing and acceptance of the next FIFO word
  always_comb begin
    state_next       = state;
    count_next       = count;
    index_next       = index;
    word_next        = word;
    nbits_next       = nbits;
    stop2_next       = stop2;
    busy_next        = busy;
    read_enable_next = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_mode_next    = par_mode;
`endif
    frame_end        = 1'b0;
    take             = 1'b0;
    bit_done         = (count == bit_length);

    case (state)
      IDLE: begin
        take = fifo.data_ready;
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          index_next = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if ((index + IDX_ONE) == nbits) begin
`ifdef UART_TX_PARITY_EN
            state_next = parity_on ? PARITY : STOP1;
`else
            state_next = STOP1;
`endif
          end else begin
            index_next = index + IDX_ONE;
          end
        end
      end
      PARITY: begin
        if (bit_done) state_next = STOP1;
      end
      STOP1: begin
        if (bit_done) begin
          if (stop2) state_next = STOP2;
          else       frame_end  = 1'b1;
        end
      end
      STOP2: begin
        if (bit_done) frame_end = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (state != IDLE) begin
      count_next = bit_done ? '0 : count + CNT_ONE;
    end

    // The last stop clock either chains straight into the next START or drops to IDLE
    if (frame_end) begin
      take = fifo.data_ready;
      if (!fifo.data_ready) begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    end

    // Accepting a word latches it together with its framing so later changes are ignored
    if (take) begin
      state_next       = START;
      count_next       = '0;
      index_next       = '0;
      word_next        = fifo.data;
      nbits_next       = nbits_in;
      stop2_next       = two_stop;
`ifdef UART_TX_PARITY_EN
      par_mode_next    = parity_mode;
`endif
      read_enable_next = 1'b1;
      busy_next        = 1'b1;
    end
  end

  // Pick the data bit for the upcoming bit slot without an oversized index select
  always_comb begin
    data_bit = 1'b1;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (int'(index_next) == i) data_bit = word_next[i];
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity over the sent bits only; seeding with mode bit 1 turns even (01) into odd (10)
  always_comb begin
    parity_bit = par_mode_next[1];
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(nbits_next)) parity_bit = parity_bit ^ word_next[i];
    end
  end
`endif

  // Line level for the next clock, registered below so txd never glitches
  always_comb begin
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = data_bit;
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_next = parity_bit;
`endif
      default: txd_next = 1'b1;
    endcase
  end

  // State and output registers; reset aborts any frame and returns the line to mark
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      index         <= '0;
      word          <= '0;
      nbits         <= '0;
      stop2         <= 1'b0;
      read_enable_q <= 1'b0;
      busy          <= 1'b0;
      txd           <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_mode      <= 2'b00;
`endif
    end else begin
      state         <= state_next;
      count         <= count_next;
      index         <= index_next;
      word          <= word_next;
      nbits         <= nbits_next;
      stop2         <= stop2_next;
      read_enable_q <= read_enable_next;
      busy          <= busy_next;
      txd           <= txd_next;
`ifdef UART_TX_PARITY_EN
      par_mode      <= par_mode_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: a queue-based FIFO feeds the DUT, each pushed word records its
// expected frame in a scoreboard, and a monitor decodes txd/busy/read_enable clock by clock.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_cfg;

  localparam int DW  = 8;
  localparam int BLW = 16;

  typedef struct {
    logic [7:0] word;
    int         n;
    bit         stop2;
    int         par;
    int         bl;
  } frame_t;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [BLW-1:0] bit_length = '0;
  logic [3:0]     num_bits = 4'd8;
  logic           two_stop = 1'b0;
  logic [1:0]     par_cfg = 2'b00;
  logic           txd;
  logic           busy;
`ifdef UART_TX_PARITY_EN
  logic [1:0]     parity_mode;
  assign parity_mode = par_cfg;
`endif

  int n_compared = 0;
  int n_failed   = 0;

  logic [7:0] words[$];
  int         rd_ptr = 0;
  bit         re_seen = 1'b0;
  frame_t     exp_q[$];

  frame_t cur;
  bit     lv[$];
  int     bi, ci, hold, fno = 0;
  bit     in_frame = 1'b0, post_check = 1'b0, post_ready = 1'b0, junk = 1'b0;

  uart_tx_cfg_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_cfg #(
    .BIT_LENGTH_WIDTH(BLW),
    .DATA_WIDTH(DW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fifo(bus),
    .bit_length(bit_length),
    .num_bits(num_bits),
    .two_stop(two_stop),
`ifdef UART_TX_PARITY_EN
    .parity_mode(parity_mode),
`endif
    .txd(txd),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    n_compared++;
    if (got !== want) begin
      n_failed++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, got, want);
    end
  endtask

  task automatic apply_stimulus(input int bl, input int nb, input bit ts, input int pm);
    bit_length = BLW'(bl);
    num_bits   = 4'(nb);
    two_stop   = ts;
    par_cfg    = 2'(pm);
  endtask

  // Push a word into the FIFO and record the frame the current configuration should produce
  task automatic send(input logic [7:0] w);
    frame_t f;
    f.word  = w;
    f.n     = ((num_bits == 0) || (num_bits > 4'd8)) ? 8 : int'(num_bits);
    f.stop2 = two_stop;
    f.bl    = int'(bit_length);
`ifdef UART_TX_PARITY_EN
    f.par   = (par_cfg == 2'b01) ? 1 : ((par_cfg == 2'b10) ? 2 : 0);
`else
    f.par   = 0;
`endif
    exp_q.push_back(f);
    words.push_back(w);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(rd_ptr >= words.size() && exp_q.size() == 0 && !in_frame && !post_check && !busy)
           && k < budget) begin
      @(posedge clock); #2;
      k++;
    end
    if (k >= budget) begin
      n_compared++;
      n_failed++;
      $display("[TB] FAIL wait_idle timeout after %0d clocks (pending frames %0d)", k, exp_q.size());
    end
    @(posedge clock); #2;
  endtask

  task automatic wait_busy(input int budget);
    int k = 0;
    while (!busy && k < budget) begin
      @(posedge clock); #2;
      k++;
    end
    if (k >= budget) begin
      n_compared++;
      n_failed++;
      $display("[TB] FAIL wait_busy timeout: busy got 0, expected 1");
    end
  endtask

  // Remember whether a pop strobe was present during the cycle now ending
  always @(negedge clock) re_seen = bus.read_enable;

  // FIFO model: apply the pop just after the edge, then present the new head word
  always @(posedge clock) begin
    #1;
    if (re_seen) rd_ptr++;
    bus.data_ready = (rd_ptr < words.size());
    bus.data       = (rd_ptr < words.size()) ? words[rd_ptr] : 8'h00;
  end

  // Monitor: match every clock of each frame against the scoreboard's expected bit sequence
  always @(negedge clock) begin
    if (reset) begin
      in_frame   = 1'b0;
      post_check = 1'b0;
      junk       = 1'b0;
    end else begin
      if (post_check) begin
        post_check = 1'b0;
        if (post_ready) check_output("gapless start {txd,busy}", {txd, busy}, 2'b01);
        else            check_output("idle after frame {txd,busy}", {txd, busy}, 2'b10);
      end
      if (bus.read_enable) check_output("data_ready during pop", bus.data_ready, 1'b1);
      if (junk) begin
        if (!busy && txd) junk = 1'b0;
      end else if (!in_frame && (txd == 1'b0 || busy)) begin
        if (exp_q.size() == 0) begin
          n_compared++;
          n_failed++;
          $display("[TB] FAIL unexpected frame: txd=%0b busy=%0b with no word queued", txd, busy);
          junk = 1'b1;
        end else begin
          logic [7:0] mask;
          int ones;
          cur = exp_q.pop_front();
          lv.delete();
          lv.push_back(1'b0);
          for (int i = 0; i < cur.n; i++) lv.push_back(cur.word[i]);
          if (cur.par != 0) begin
            mask = 8'((1 << cur.n) - 1);
            ones = $countones(cur.word & mask);
            lv.push_back(ones[0] ^ (cur.par == 2));
          end
          lv.push_back(1'b1);
          if (cur.stop2) lv.push_back(1'b1);
          hold     = cur.bl + 1;
          bi       = 0;
          ci       = 0;
          in_frame = 1'b1;
          fno++;
        end
      end
      if (in_frame) begin
        bit first;
        first = (bi == 0 && ci == 0);
        check_output($sformatf("frame %0d bit %0d clk %0d {txd,busy,re}", fno, bi, ci),
                     {txd, busy, bus.read_enable}, {lv[bi], 1'b1, first});
        ci++;
        if (ci == hold) begin
          ci = 0;
          bi++;
          if (bi == lv.size()) begin
            in_frame   = 1'b0;
            post_check = 1'b1;
            post_ready = bus.data_ready;
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized bursts
  initial begin
    int pops_before;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_output("reset state {txd,busy,re}", {txd, busy, bus.read_enable}, 3'b100);
    @(posedge clock); #2;
    reset = 1'b0;

    apply_stimulus(3, 8, 1'b0, 0);
    send(8'hA5);
    wait_idle(1000);

`ifdef UART_TX_PARITY_EN
    apply_stimulus(2, 7, 1'b0, 1);
    send(8'hFF);
    wait_idle(1000);
    apply_stimulus(2, 7, 1'b0, 2);
    send(8'hFF);
    wait_idle(1000);
`endif

    pops_before = rd_ptr;
    apply_stimulus(0, 8, 1'b1, 0);
    send(8'h12);
    send(8'hED);
    send(8'h6B);
    wait_idle(1000);
    check_output("read_enable pulses for 3-word burst", 32'(rd_ptr - pops_before), 32'd3);

    apply_stimulus(1, 8, 1'b0, 0);
    send(8'h3C);
    wait_busy(50);
    repeat (4 * 2) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    check_output("reset mid-frame {txd,busy,re}", {txd, busy, bus.read_enable}, 3'b100);
    @(posedge clock); #2;
    send(8'h96);
    wait_idle(1000);

    apply_stimulus(1, 8, 1'b0, 0);
    send(8'hC3);
    wait_busy(50);
    apply_stimulus(1, 5, 1'b1, 0);
    send(8'h5A);
    wait_idle(1000);

    apply_stimulus(0, 0, 1'b0, 0);
    send(8'h81);
    wait_idle(1000);
    apply_stimulus(0, 12, 1'b0, 0);
    send(8'h7E);
    wait_idle(1000);

    for (int it = 0; it < 30; it++) begin
      int burst;
      apply_stimulus($urandom_range(3, 0), $urandom_range(15, 0), 1'($urandom_range(1, 0)),
                     $urandom_range(3, 0));
      burst = $urandom_range(3, 1);
      for (int b = 0; b < burst; b++) send(8'($urandom));
      wait_idle(2000);
    end

    check_output("total read_enable pulses", 32'(rd_ptr), 32'(words.size()));
    check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
